collision_scorer: RTL and testbench

COLLISION_SCORER -- requirements
Module: collision_scorer

---
 rtl/collision_scorer_if.sv | 25 ++
 rtl/collision_scorer.sv | 130 +++++++++++++
 tb/tb_collision_scorer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/collision_scorer_if.sv
// Pixel-timing inputs and scoring/colour outputs of the collision scorer,
// bundled so the renderer side and the scorer side share one connection.
interface collision_scorer_if;
    logic [9:0] HCounter;
    logic [9:0] VCounter;
    logic       meteor_px;
    logic       switch;
    logic       start;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [2:0] rgb;

    modport master (
        output HCounter, VCounter, meteor_px, switch, start,
        input  score, lives, game_over, hit_pulse, miss_pulse, rgb
    );

    modport slave (
        input  HCounter, VCounter, meteor_px, switch, start,
        output score, lives, game_over, hit_pulse, miss_pulse, rgb
    );
endinterface

// File: rtl/collision_scorer.sv
// Collision scorer: watches meteor pixels during a frame, and at frame end
// decides hit / miss / re-arm, tracks score and lives, and colours pixels.
module collision_scorer #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int DEF_TOP     = 376,
    parameter int DEF_BOT     = 416,
    parameter int MISS_ROW    = 500,
    parameter int ARM_ROW     = 100,
    parameter int START_LIVES = 3
) (
    input logic               clk,
    input logic               reset,
    collision_scorer_if.slave bus
);
    localparam logic [9:0] H_VIS_LO = 10'd144;
    localparam logic [9:0] H_VIS_HI = 10'd784;
    localparam logic [9:0] V_VIS_LO = 10'd35;
    localparam logic [9:0] V_VIS_HI = 10'd515;

    typedef enum logic {PLAY, GAME_OVER} state_t;

    state_t     state, state_next;
    logic       armed;
    logic       hit_seen, low_seen, top_seen;
    logic [7:0] score;
    logic [1:0] lives;
    logic       commit, in_band, visible;
    logic       do_hit, do_miss, do_arm, do_restart;

    assign commit  = (bus.HCounter == 10'(H_TOTAL - 1)) && (bus.VCounter == 10'(V_TOTAL - 1));
    assign in_band = (bus.VCounter >= 10'(DEF_TOP)) && (bus.VCounter <= 10'(DEF_BOT));
    assign visible = (bus.HCounter >= H_VIS_LO) && (bus.HCounter < H_VIS_HI) &&
                     (bus.VCounter >= V_VIS_LO) && (bus.VCounter < V_VIS_HI);

    assign bus.score     = score;
    assign bus.lives     = lives;
    assign bus.game_over = (state == GAME_OVER);

    // Frame-end decision: hit wins over miss; re-arm only on a clean top-only frame.
    always_comb begin
        state_next = state;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_arm     = 1'b0;
        do_restart = 1'b0;
        case (state)
            PLAY: begin
                if (commit) begin
                    if (armed && hit_seen) begin
                        do_hit = 1'b1;
                    end else if (armed && low_seen) begin
                        do_miss = 1'b1;
                        if (lives <= 2'd1) state_next = GAME_OVER;
                    end else if (!armed && top_seen && !hit_seen && !low_seen) begin
                        do_arm = 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                if (commit && bus.start) begin
                    do_restart = 1'b1;
                    state_next = PLAY;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PLAY;
        else       state <= state_next;
    end

    // Per-frame flags: accumulate in PLAY, cleared at every commit and while game over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_seen <= 1'b0;
            low_seen <= 1'b0;
            top_seen <= 1'b0;
        end else if (commit || state != PLAY) begin
            hit_seen <= 1'b0;
            low_seen <= 1'b0;
            top_seen <= 1'b0;
        end else if (bus.meteor_px) begin
            if (in_band && bus.switch)             hit_seen <= 1'b1;
            if (bus.VCounter >= 10'(MISS_ROW))     low_seen <= 1'b1;
            if (bus.VCounter < 10'(ARM_ROW))       top_seen <= 1'b1;
        end
    end

    // Score, lives, arming and one-cycle event strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score          <= 8'd0;
            lives          <= 2'(START_LIVES);
            armed          <= 1'b1;
            bus.hit_pulse  <= 1'b0;
            bus.miss_pulse <= 1'b0;
        end else begin
            bus.hit_pulse  <= do_hit;
            bus.miss_pulse <= do_miss;
            if (do_hit) begin
                if (score != 8'hFF) score <= score + 8'd1;
                armed <= 1'b0;
            end
            if (do_miss) begin
                if (lives != 2'd0) lives <= lives - 2'd1;
                armed <= 1'b0;
            end
            if (do_arm) armed <= 1'b1;
            if (do_restart) begin
                score <= 8'd0;
                lives <= 2'(START_LIVES);
                armed <= 1'b1;
            end
        end
    end

    // Pixel colour, one cycle behind the counters: meteor, game-over, defense band.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    bus.rgb <= 3'b000;
        else if (!visible)            bus.rgb <= 3'b000;
        else if (bus.meteor_px)       bus.rgb <= 3'b111;
        else if (state == GAME_OVER)  bus.rgb <= 3'b100;
        else if (in_band && bus.switch) bus.rgb <= 3'b010;
        else                          bus.rgb <= 3'b000;
    end
endmodule

// File: tb/tb_collision_scorer.sv
// Directed bench for collision_scorer: a frame-level scoring model is updated
// per driven cycle and compared against the DUT on every falling edge.
module tb_collision_scorer;
    localparam int HT = 800;
    localparam int VT = 525;

    logic clk = 1'b0;
    logic reset = 1'b1;
    collision_scorer_if bus();

    collision_scorer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int   m_score, m_lives;
    bit   m_armed, m_over, m_hit, m_low, m_top, m_hp, m_mp;
    int   m_rgb;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_lives = 3; m_armed = 1; m_over = 0;
        m_hit = 0; m_low = 0; m_top = 0; m_hp = 0; m_mp = 0; m_rgb = 0;
    endtask

    // One pixel clock: drive inputs, then advance the model with what the edge sampled.
    task automatic cyc(input int h, input int v, input bit m, input bit sw, input bit st);
        int nrgb;
        bit vis;
        bus.HCounter = 10'(h); bus.VCounter = 10'(v);
        bus.meteor_px = m; bus.switch = sw; bus.start = st;
        @(posedge clk);
        vis  = (h >= 144 && h < 784 && v >= 35 && v < 515);
        nrgb = !vis ? 0 : m ? 7 : m_over ? 4 : (v >= 376 && v <= 416 && sw) ? 2 : 0;
        m_hp = 0; m_mp = 0;
        if (h == HT-1 && v == VT-1) begin
            if (!m_over) begin
                if (m_armed && m_hit) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_armed = 0; m_hp = 1;
                end else if (m_armed && m_low) begin
                    m_lives = m_lives - 1; m_armed = 0; m_mp = 1;
                    if (m_lives == 0) m_over = 1;
                end else if (!m_armed && m_top && !m_hit && !m_low) begin
                    m_armed = 1;
                end
            end else if (st) begin
                m_score = 0; m_lives = 3; m_armed = 1; m_over = 0;
            end
            m_hit = 0; m_low = 0; m_top = 0;
        end else if (!m_over && m) begin
            if (v >= 376 && v <= 416 && sw) m_hit = 1;
            if (v >= 500) m_low = 1;
            if (v < 100)  m_top = 1;
        end
        m_rgb = nrgb;
        @(negedge clk); #1;
    endtask

    task automatic px(input int v, input bit sw);
        cyc(300, v, 1'b1, sw, 1'b0);
    endtask

    task automatic commit(input bit st);
        cyc(HT-1, VT-1, 1'b0, 1'b0, st);
    endtask

    // Every cycle out of reset, DUT outputs must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("score",      int'(bus.score),      m_score);
            chk("lives",      int'(bus.lives),      m_lives);
            chk("game_over",  int'(bus.game_over),  int'(m_over));
            chk("hit_pulse",  int'(bus.hit_pulse),  int'(m_hp));
            chk("miss_pulse", int'(bus.miss_pulse), int'(m_mp));
            chk("rgb",        int'(bus.rgb),        m_rgb);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_score"}, int'(bus.score), 0);
        chk({tag, "_lives"}, int'(bus.lives), 3);
        chk({tag, "_go"},    int'(bus.game_over), 0);
        chk({tag, "_hp"},    int'(bus.hit_pulse), 0);
        chk({tag, "_mp"},    int'(bus.miss_pulse), 0);
        chk({tag, "_rgb"},   int'(bus.rgb), 0);
    endtask

    initial begin
        model_reset();
        bus.HCounter = '0; bus.VCounter = '0; bus.meteor_px = 0; bus.switch = 0; bus.start = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("por");
        reset = 1'b0;

        // armed hit in the defense band, then same frame again while disarmed
        px(380, 1); px(381, 1); commit(0);
        chk("hit1_score_lit", int'(bus.score), 1);
        chk("hit1_pulse_lit", int'(bus.hit_pulse), 1);
        cyc(200, 200, 0, 0, 0);
        px(380, 1); commit(0);
        chk("hit2_noscore_lit", int'(bus.score), 1);

        // arm at the top, then miss with switch off
        px(40, 0); commit(0);
        px(505, 0); commit(0);
        chk("miss_lives_lit", int'(bus.lives), 2);
        chk("miss_pulse_lit", int'(bus.miss_pulse), 1);

        // hit and low in the same armed frame score the hit only
        px(40, 0); commit(0);
        px(390, 1); px(505, 0); commit(0);
        chk("both_score_lit", int'(bus.score), 2);
        chk("both_lives_lit", int'(bus.lives), 2);

        // near-frame-end counters and start in PLAY change nothing
        px(40, 0); cyc(HT-1, VT-2, 1, 0, 1); cyc(HT-2, VT-1, 0, 0, 1);
        commit(1);
        chk("play_start_ign_lit", int'(bus.score), 2);

        // three misses from reset end the game
        @(negedge clk); #1; reset = 1'b1; model_reset();
        @(negedge clk); #1; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            px(505, 0); commit(0);
            if (i < 2) begin px(40, 0); commit(0); end
        end
        chk("over_lives_lit", int'(bus.lives), 0);
        chk("over_go_lit", int'(bus.game_over), 1);
        px(380, 1);                      // meteor still wins the colour
        cyc(300, 200, 0, 0, 1);          // start outside commit ignored
        chk("over_rgb_lit", int'(bus.rgb), 4);
        px(505, 0); commit(0);
        chk("over_hold_lit", int'(bus.game_over), 1);
        commit(1);
        chk("restart_lives_lit", int'(bus.lives), 3);
        chk("restart_go_lit", int'(bus.game_over), 0);

        // saturate score at 255, and keep pulsing on further hits
        for (int i = 0; i < 256; i++) begin
            px(380, 1); commit(0);
            px(40, 0); commit(0);
        end
        chk("sat_score_lit", int'(bus.score), 255);
        px(380, 1); commit(0);
        chk("sat_hold_lit", int'(bus.score), 255);
        chk("sat_pulse_lit", int'(bus.hit_pulse), 1);

        // colour path
        cyc(300, 200, 1, 0, 0);
        chk("rgb_meteor_lit", int'(bus.rgb), 7);
        cyc(100, 200, 1, 0, 0);
        chk("rgb_blank_lit", int'(bus.rgb), 0);
        cyc(300, 380, 0, 1, 0);
        chk("rgb_band_lit", int'(bus.rgb), 2);

        // mid-frame reset discards the partial hit
        px(40, 0); commit(0);
        px(380, 1);
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        model_reset();
        @(negedge clk); #1; reset = 1'b0;
        commit(0);
        chk("post_reset_noscore_lit", int'(bus.score), 0);
        chk("post_reset_hp_lit", int'(bus.hit_pulse), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
